pic_rw_seq_logic: RTL and testbench

- Clocked, parametrised read/write logic for the 8259A PIC.
- Synchronises the asynchronous CPU bus strobes and sequences initialisation ICW1 -> ICW2 -> [ICW3] -> [ICW4] with a state machine. After initialisation it decodes OCW1-3 writes.
- Notifies the control logic of every committed write through a flag/ack handshake.
- Sits between the data bus buffer and the control logic.

---
 rtl/pic_pkg.sv | 48 ++++
 rtl/pic_sync_stage.sv | 29 ++
 rtl/pic_rw_seq_logic.sv | 231 +++++++++++++++++++++++
 tb/tb_pic_rw_seq_logic.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pic_pkg.sv
// Shared definitions for the 8259A PIC read/write sequencing logic.
// Holds the initialisation state encoding, write_sel bit positions and
// one-hot codes, and the control-word bit positions used by the decoder.
package pic_pkg;

  // Initialisation / operating states.
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WAIT_ICW2 = 3'd1,
    WAIT_ICW3 = 3'd2,
    WAIT_ICW4 = 3'd3,
    READY     = 3'd4
  } pic_state_e;

  // write_sel bit positions. OCW1 sits at bit 5 and OCW2 at bit 4 so that
  // an OCW1 commit reads back as 0x20 and an OCW3 commit as 0x40.
  localparam int SEL_W    = 7;
  localparam int SEL_ICW1 = 0;
  localparam int SEL_ICW2 = 1;
  localparam int SEL_ICW3 = 2;
  localparam int SEL_ICW4 = 3;
  localparam int SEL_OCW2 = 4;
  localparam int SEL_OCW1 = 5;
  localparam int SEL_OCW3 = 6;

  // One-hot write_sel codes.
  localparam logic [SEL_W-1:0] SEL_ICW1_OH = 7'b000_0001;
  localparam logic [SEL_W-1:0] SEL_ICW2_OH = 7'b000_0010;
  localparam logic [SEL_W-1:0] SEL_ICW3_OH = 7'b000_0100;
  localparam logic [SEL_W-1:0] SEL_ICW4_OH = 7'b000_1000;
  localparam logic [SEL_W-1:0] SEL_OCW2_OH = 7'b001_0000;
  localparam logic [SEL_W-1:0] SEL_OCW1_OH = 7'b010_0000;
  localparam logic [SEL_W-1:0] SEL_OCW3_OH = 7'b100_0000;

  // Control-word bit positions.
  localparam int IC4_BIT       = 0;  // ICW1: ICW4 needed
  localparam int SNGL_BIT      = 1;  // ICW1: single (no ICW3)
  localparam int ICW1_MARK_BIT = 4;  // a0=0 write with this bit set is ICW1
  localparam int OCW3_MARK_BIT = 3;  // distinguishes OCW3 from OCW2
  localparam int RIS_BIT       = 0;  // OCW3: read ISR (vs IRR)
  localparam int RR_BIT        = 1;  // OCW3: read register enable

  // True when OCW3 selects ISR for readback (RR=1, RIS=1).
  function automatic logic read_isr_sel(input logic [7:0] ocw3_val);
    return ocw3_val[RR_BIT] & ocw3_val[RIS_BIT];
  endfunction

endpackage

// File: rtl/pic_sync_stage.sv
// N-flop synchroniser for asynchronous bus inputs.
// Parameters: SYNC_STAGES (flop depth, 1-4), WIDTH, RST_VAL (idle level).
// Ports: clk, rst_n (async active-low), d (async input), q (synced output).
module pic_sync_stage #(
  parameter int               SYNC_STAGES = 2,
  parameter int               WIDTH       = 1,
  parameter logic [WIDTH-1:0] RST_VAL     = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stage_r [SYNC_STAGES];

  // Shift chain; resets to the bus idle level so no false edge is seen.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) stage_r[i] <= RST_VAL;
    end else begin
      stage_r[0] <= d;
      for (int i = 1; i < SYNC_STAGES; i++) stage_r[i] <= stage_r[i-1];
    end
  end

  assign q = stage_r[SYNC_STAGES-1];

endmodule

// File: rtl/pic_rw_seq_logic.sv
// 8259A PIC read/write sequencing logic.
// Synchronises the CPU bus strobes, runs the ICW1..ICW4 initialisation
// sequence, decodes OCW1-3 once READY and reports every committed write to
// the control logic through write_flag/write_sel with write_flag_ack.
// Ports: clk, rst_n, cs_n, wr_n, rd_n, a0, din[7:0], write_flag_ack,
//   irr/isr (readback sources), icw1-4, ocw1-3, init_done, write_flag,
//   write_sel[6:0], overrun, read_cmd_to_ctrl_logic, dout[7:0], dout_oe.
// Optional: define PIC_READBACK_EN to drive dout/dout_oe from
//   ocw1/irr/isr; otherwise dout and dout_oe are tied to zero.
module pic_rw_seq_logic
  import pic_pkg::*;
#(
  parameter int         SYNC_STAGES = 2,
  parameter logic [7:0] OCW1_INIT   = 8'h00,
  parameter logic [7:0] OCW3_INIT   = 8'h0A
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cs_n,
  input  logic             wr_n,
  input  logic             rd_n,
  input  logic             a0,
  input  logic [7:0]       din,
  input  logic             write_flag_ack,
  input  logic [7:0]       irr,
  input  logic [7:0]       isr,
  output logic [7:0]       icw1,
  output logic [7:0]       icw2,
  output logic [7:0]       icw3,
  output logic [7:0]       icw4,
  output logic [7:0]       ocw1,
  output logic [7:0]       ocw2,
  output logic [7:0]       ocw3,
  output logic             init_done,
  output logic             write_flag,
  output logic [SEL_W-1:0] write_sel,
  output logic             overrun,
  output logic             read_cmd_to_ctrl_logic,
  output logic [7:0]       dout,
  output logic             dout_oe
);

  logic             cs_n_s, wr_n_s, rd_n_s, a0_s;
  logic [7:0]       din_s;
  logic             wr_n_prev_r;
  logic             commit_s, accept_s;
  logic [SEL_W-1:0] sel_s;
  pic_state_e       state_r, state_nx_s;
  logic [7:0]       icw1_r, icw2_r, icw3_r, icw4_r, ocw1_r, ocw2_r, ocw3_r;
  logic             init_done_r, write_flag_r, overrun_r, read_cmd_r;
  logic [SEL_W-1:0] write_sel_r;

  pic_sync_stage #(
    .SYNC_STAGES (SYNC_STAGES),
    .WIDTH       (12),
    .RST_VAL     (12'hE00)
  ) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     ({cs_n, wr_n, rd_n, a0, din}),
    .q     ({cs_n_s, wr_n_s, rd_n_s, a0_s, din_s})
  );

  // A write commits on the synced wr_n rising edge while selected.
  assign commit_s = wr_n_s & ~wr_n_prev_r & ~cs_n_s;

  // Decode the committed write against the current state.
  always_comb begin
    accept_s   = 1'b0;
    sel_s      = {SEL_W{1'b0}};
    state_nx_s = state_r;
    if (commit_s) begin
      if (!a0_s && din_s[ICW1_MARK_BIT]) begin
        // ICW1 restarts initialisation from any state.
        accept_s   = 1'b1;
        sel_s      = SEL_ICW1_OH;
        state_nx_s = WAIT_ICW2;
      end else begin
        case (state_r)
          WAIT_ICW2: begin
            if (a0_s) begin
              accept_s = 1'b1;
              sel_s    = SEL_ICW2_OH;
              if (!icw1_r[SNGL_BIT])    state_nx_s = WAIT_ICW3;
              else if (icw1_r[IC4_BIT]) state_nx_s = WAIT_ICW4;
              else                      state_nx_s = READY;
            end else begin
              state_nx_s = state_r;
            end
          end
          WAIT_ICW3: begin
            if (a0_s) begin
              accept_s   = 1'b1;
              sel_s      = SEL_ICW3_OH;
              state_nx_s = icw1_r[IC4_BIT] ? WAIT_ICW4 : READY;
            end else begin
              state_nx_s = state_r;
            end
          end
          WAIT_ICW4: begin
            if (a0_s) begin
              accept_s   = 1'b1;
              sel_s      = SEL_ICW4_OH;
              state_nx_s = READY;
            end else begin
              state_nx_s = state_r;
            end
          end
          READY: begin
            // With a0=0, din[4]=1 was already taken as ICW1, so only the
            // 00 (OCW2) and 01 (OCW3) codes reach this point.
            accept_s = 1'b1;
            if (a0_s)                        sel_s = SEL_OCW1_OH;
            else if (din_s[OCW3_MARK_BIT])   sel_s = SEL_OCW3_OH;
            else                             sel_s = SEL_OCW2_OH;
          end
          default: begin
            accept_s   = 1'b0;
            state_nx_s = state_r;
          end
        endcase
      end
    end else begin
      accept_s = 1'b0;
    end
  end

  // State, edge history and read-command registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      init_done_r <= 1'b0;
      wr_n_prev_r <= 1'b1;
      read_cmd_r  <= 1'b0;
    end else begin
      state_r     <= state_nx_s;
      init_done_r <= (state_nx_s == READY);
      wr_n_prev_r <= wr_n_s;
      // A read overlapping a write strobe is suppressed.
      read_cmd_r  <= ~rd_n_s & ~cs_n_s & wr_n_s;
    end
  end

  // Control-word registers, loaded on accepted commits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      icw1_r <= 8'h00;
      icw2_r <= 8'h00;
      icw3_r <= 8'h00;
      icw4_r <= 8'h00;
      ocw1_r <= OCW1_INIT;
      ocw2_r <= 8'h00;
      ocw3_r <= OCW3_INIT;
    end else if (accept_s) begin
      case (sel_s)
        SEL_ICW1_OH: begin
          icw1_r <= din_s;
          icw3_r <= 8'h00;
          icw4_r <= 8'h00;
          ocw1_r <= OCW1_INIT;
          ocw3_r <= OCW3_INIT;
        end
        SEL_ICW2_OH: icw2_r <= din_s;
        SEL_ICW3_OH: icw3_r <= din_s;
        SEL_ICW4_OH: icw4_r <= din_s;
        SEL_OCW1_OH: ocw1_r <= din_s;
        SEL_OCW2_OH: ocw2_r <= din_s;
        SEL_OCW3_OH: ocw3_r <= din_s;
        default:     icw1_r <= icw1_r;
      endcase
    end
  end

  // Write notification handshake; a new commit takes priority over ack.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      write_flag_r <= 1'b0;
      write_sel_r  <= {SEL_W{1'b0}};
      overrun_r    <= 1'b0;
    end else if (accept_s) begin
      write_flag_r <= 1'b1;
      write_sel_r  <= sel_s;
      overrun_r    <= write_flag_r & ~write_flag_ack;
    end else if (write_flag_ack) begin
      write_flag_r <= 1'b0;
      write_sel_r  <= {SEL_W{1'b0}};
      overrun_r    <= 1'b0;
    end else begin
      overrun_r    <= 1'b0;
    end
  end

`ifdef PIC_READBACK_EN
  logic [7:0] dout_r;

  // Readback data mux, registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout_r <= 8'h00;
    end else if (a0_s) begin
      dout_r <= ocw1_r;
    end else if (read_isr_sel(ocw3_r)) begin
      dout_r <= isr;
    end else begin
      dout_r <= irr;
    end
  end

  assign dout    = dout_r;
  assign dout_oe = read_cmd_r;
`else
  logic unused_readback_s;
  assign unused_readback_s = ^{irr, isr};
  assign dout    = 8'h00;
  assign dout_oe = 1'b0;
`endif

  assign icw1                   = icw1_r;
  assign icw2                   = icw2_r;
  assign icw3                   = icw3_r;
  assign icw4                   = icw4_r;
  assign ocw1                   = ocw1_r;
  assign ocw2                   = ocw2_r;
  assign ocw3                   = ocw3_r;
  assign init_done              = init_done_r;
  assign write_flag             = write_flag_r;
  assign write_sel              = write_sel_r;
  assign overrun                = overrun_r;
  assign read_cmd_to_ctrl_logic = read_cmd_r;

endmodule

// File: tb/tb_pic_rw_seq_logic.sv
// Self-checking bench for pic_rw_seq_logic: a table of bus writes with
// expected write_sel / init_done / register values, plus hand-written
// sequences for overrun, ack/commit collision, read suppression, readback,
// re-initialisation and mid-sequence reset.
module tb_pic_rw_seq_logic;

  localparam int         SYNC      = 2;
  localparam logic [7:0] OCW1_RST  = 8'h00;
  localparam logic [7:0] OCW3_RST  = 8'h0A;

  logic       clk = 1'b0;
  logic       rst_n, cs_n, wr_n, rd_n, a0, write_flag_ack;
  logic [7:0] din, irr, isr;
  logic [7:0] icw1, icw2, icw3, icw4, ocw1, ocw2, ocw3, dout;
  logic       init_done, write_flag, overrun, read_cmd_to_ctrl_logic, dout_oe;
  logic [6:0] write_sel;

  int n_cmp = 0;
  int n_err = 0;
  int ovr_cnt = 0;
  int ovr_base;

  always #5 clk = ~clk;

  pic_rw_seq_logic #(
    .SYNC_STAGES (SYNC),
    .OCW1_INIT   (OCW1_RST),
    .OCW3_INIT   (OCW3_RST)
  ) dut (
    .clk                    (clk),
    .rst_n                  (rst_n),
    .cs_n                   (cs_n),
    .wr_n                   (wr_n),
    .rd_n                   (rd_n),
    .a0                     (a0),
    .din                    (din),
    .write_flag_ack         (write_flag_ack),
    .irr                    (irr),
    .isr                    (isr),
    .icw1                   (icw1),
    .icw2                   (icw2),
    .icw3                   (icw3),
    .icw4                   (icw4),
    .ocw1                   (ocw1),
    .ocw2                   (ocw2),
    .ocw3                   (ocw3),
    .init_done              (init_done),
    .write_flag             (write_flag),
    .write_sel              (write_sel),
    .overrun                (overrun),
    .read_cmd_to_ctrl_logic (read_cmd_to_ctrl_logic),
    .dout                   (dout),
    .dout_oe                (dout_oe)
  );

  // Count overrun pulses (one per high cycle).
  always @(posedge clk) if (rst_n && overrun) ovr_cnt++;

  // Watchdog.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic       a0;
    logic [7:0] data;
    logic [6:0] exp_sel;
    logic       exp_init;
    logic [7:0] exp_reg;
  } vec_t;

  vec_t vecs [11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] reg_by_sel(input logic [6:0] sel);
    case (sel)
      7'h01:   return icw1;
      7'h02:   return icw2;
      7'h04:   return icw3;
      7'h08:   return icw4;
      7'h10:   return ocw2;
      7'h20:   return ocw1;
      7'h40:   return ocw3;
      default: return 8'h00;
    endcase
  endfunction

  // One bus write; optionally raise ack exactly in the commit cycle.
  task automatic bus_write(input logic a, input logic [7:0] d, input logic ack_at_commit);
    @(negedge clk);
    cs_n = 1'b0; a0 = a; din = d; wr_n = 1'b0;
    repeat (3) @(negedge clk);
    wr_n = 1'b1;
    if (ack_at_commit) begin
      repeat (SYNC) @(negedge clk);
      write_flag_ack = 1'b1;
      @(negedge clk);
      write_flag_ack = 1'b0;
      repeat (2) @(negedge clk);
    end else begin
      repeat (SYNC + 3) @(negedge clk);
    end
    cs_n = 1'b1;
    repeat (SYNC + 1) @(negedge clk);
  endtask

  task automatic do_ack();
    @(negedge clk);
    write_flag_ack = 1'b1;
    @(negedge clk);
    write_flag_ack = 1'b0;
  endtask

  task automatic read_begin(input logic a);
    @(negedge clk);
    cs_n = 1'b0; a0 = a; rd_n = 1'b0;
    repeat (SYNC + 3) @(negedge clk);
  endtask

  task automatic read_end();
    rd_n = 1'b1; cs_n = 1'b1;
    repeat (SYNC + 2) @(negedge clk);
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, " icw1"}, icw1, 8'h00);
    chk({tag, " icw2"}, icw2, 8'h00);
    chk({tag, " icw3"}, icw3, 8'h00);
    chk({tag, " icw4"}, icw4, 8'h00);
    chk({tag, " ocw1"}, ocw1, OCW1_RST);
    chk({tag, " ocw2"}, ocw2, 8'h00);
    chk({tag, " ocw3"}, ocw3, OCW3_RST);
    chk({tag, " init_done"}, init_done, 1'b0);
    chk({tag, " write_flag"}, write_flag, 1'b0);
    chk({tag, " write_sel"}, write_sel, 7'h00);
    chk({tag, " overrun"}, overrun, 1'b0);
    chk({tag, " read_cmd"}, read_cmd_to_ctrl_logic, 1'b0);
    chk({tag, " dout"}, dout, 8'h00);
    chk({tag, " dout_oe"}, dout_oe, 1'b0);
  endtask

  initial begin
    //            a0    data   sel    init  reg
    vecs[0]  = '{1'b1, 8'h55, 7'h00, 1'b0, 8'h00}; // a0=1 in IDLE: ignored
    vecs[1]  = '{1'b0, 8'h12, 7'h01, 1'b0, 8'h12}; // ICW1 single, no IC4
    vecs[2]  = '{1'b1, 8'h20, 7'h02, 1'b1, 8'h20}; // ICW2 -> READY
    vecs[3]  = '{1'b0, 8'h11, 7'h01, 1'b0, 8'h11}; // ICW1 cascade + IC4
    vecs[4]  = '{1'b1, 8'h08, 7'h02, 1'b0, 8'h08}; // ICW2 -> WAIT_ICW3
    vecs[5]  = '{1'b0, 8'h00, 7'h00, 1'b0, 8'h00}; // OCW2 while initialising: ignored
    vecs[6]  = '{1'b1, 8'h04, 7'h04, 1'b0, 8'h04}; // ICW3 -> WAIT_ICW4
    vecs[7]  = '{1'b1, 8'h01, 7'h08, 1'b1, 8'h01}; // ICW4 -> READY
    vecs[8]  = '{1'b1, 8'hFF, 7'h20, 1'b1, 8'hFF}; // OCW1
    vecs[9]  = '{1'b0, 8'h20, 7'h10, 1'b1, 8'h20}; // OCW2
    vecs[10] = '{1'b0, 8'h0B, 7'h40, 1'b1, 8'h0B}; // OCW3

    rst_n = 1'b0; cs_n = 1'b1; wr_n = 1'b1; rd_n = 1'b1; a0 = 1'b0;
    din = 8'h00; write_flag_ack = 1'b0; irr = 8'hA5; isr = 8'h3C;
    repeat (3) @(negedge clk);
    chk_reset_state("reset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Table-driven write sequence.
    for (int i = 0; i < 11; i++) begin
      bus_write(vecs[i].a0, vecs[i].data, 1'b0);
      chk($sformatf("vec%0d write_flag", i), write_flag, (vecs[i].exp_sel != 7'h00));
      chk($sformatf("vec%0d write_sel", i), write_sel, vecs[i].exp_sel);
      chk($sformatf("vec%0d init_done", i), init_done, vecs[i].exp_init);
      if (vecs[i].exp_sel != 7'h00) begin
        chk($sformatf("vec%0d reg", i), reg_by_sel(vecs[i].exp_sel), vecs[i].exp_reg);
        do_ack();
        chk($sformatf("vec%0d ack flag", i), write_flag, 1'b0);
        chk($sformatf("vec%0d ack sel", i), write_sel, 7'h00);
      end else begin
        chk($sformatf("vec%0d ocw1 kept", i), ocw1, OCW1_RST);
        chk($sformatf("vec%0d ocw2 kept", i), ocw2, 8'h00);
      end
      if (i == 1) begin
        chk("icw1 clears icw3", icw3, 8'h00);
        chk("icw1 loads ocw3", ocw3, OCW3_RST);
      end
    end
    chk("cascade icw1", icw1, 8'h11);
    chk("cascade icw2", icw2, 8'h08);
    chk("cascade icw3", icw3, 8'h04);
    chk("cascade icw4", icw4, 8'h01);

    // Overrun: two OCW1 commits without ack.
    ovr_base = ovr_cnt;
    bus_write(1'b1, 8'h0F, 1'b0);
    chk("ovr first none", ovr_cnt - ovr_base, 0);
    bus_write(1'b1, 8'h33, 1'b0);
    chk("ovr pulse once", ovr_cnt - ovr_base, 1);
    chk("ovr write_sel", write_sel, 7'h20);
    chk("ovr flag", write_flag, 1'b1);
    chk("ovr ocw1", ocw1, 8'h33);

    // Commit coincident with ack: flag stays, no new overrun.
    bus_write(1'b1, 8'h44, 1'b1);
    chk("coinc overrun", ovr_cnt - ovr_base, 1);
    chk("coinc flag", write_flag, 1'b1);
    chk("coinc write_sel", write_sel, 7'h20);
    chk("coinc ocw1", ocw1, 8'h44);
    do_ack();
    chk("coinc ack flag", write_flag, 1'b0);

    // Read overlapping write: read suppressed, write proceeds.
    @(negedge clk);
    cs_n = 1'b0; a0 = 1'b1; din = 8'h66; wr_n = 1'b0; rd_n = 1'b0;
    repeat (SYNC + 3) @(negedge clk);
    chk("rw overlap read_cmd", read_cmd_to_ctrl_logic, 1'b0);
    wr_n = 1'b1; rd_n = 1'b1;
    repeat (SYNC + 3) @(negedge clk);
    cs_n = 1'b1;
    repeat (SYNC + 1) @(negedge clk);
    chk("rw overlap flag", write_flag, 1'b1);
    chk("rw overlap ocw1", ocw1, 8'h66);
    do_ack();

    // Plain reads; ocw3 = 0x0B selects ISR.
    read_begin(1'b0);
    chk("read a0=0 read_cmd", read_cmd_to_ctrl_logic, 1'b1);
`ifdef PIC_READBACK_EN
    chk("read a0=0 dout isr", dout, 8'h3C);
    chk("read a0=0 dout_oe", dout_oe, 1'b1);
`else
    chk("read a0=0 dout off", dout, 8'h00);
    chk("read a0=0 dout_oe off", dout_oe, 1'b0);
`endif
    read_end();
    chk("read end read_cmd", read_cmd_to_ctrl_logic, 1'b0);
    chk("read end dout_oe", dout_oe, 1'b0);
    read_begin(1'b1);
`ifdef PIC_READBACK_EN
    chk("read a0=1 dout ocw1", dout, 8'h66);
    chk("read a0=1 dout_oe", dout_oe, 1'b1);
`else
    chk("read a0=1 dout off", dout, 8'h00);
`endif
    read_end();

    // Re-init mid-sequence: ICW1, ICW2, then ICW1 again before ICW3.
    bus_write(1'b0, 8'h11, 1'b0); do_ack();
    bus_write(1'b1, 8'h08, 1'b0); do_ack();
    bus_write(1'b0, 8'h11, 1'b0);
    chk("reinit write_sel", write_sel, 7'h01);
    chk("reinit init_done", init_done, 1'b0);
    chk("reinit ocw1", ocw1, OCW1_RST);
    chk("reinit ocw3", ocw3, OCW3_RST);
    chk("reinit icw3", icw3, 8'h00);
    do_ack();
    bus_write(1'b1, 8'h77, 1'b0);
    chk("reinit icw2 sel", write_sel, 7'h02);
    chk("reinit icw2", icw2, 8'h77);
    chk("reinit still init", init_done, 1'b0);
    do_ack();

    // ocw3 back at 0x0A selects IRR.
    read_begin(1'b0);
`ifdef PIC_READBACK_EN
    chk("read irr dout", dout, 8'hA5);
`else
    chk("read irr dout off", dout, 8'h00);
`endif
    read_end();

    // ICW3 left unacked, now in WAIT_ICW4; reset mid-cycle.
    bus_write(1'b1, 8'h05, 1'b0);
    chk("pre-reset sel", write_sel, 7'h04);
    chk("pre-reset flag", write_flag, 1'b1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk_reset_state("midreset");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Back in IDLE: a0=1 write is ignored.
    bus_write(1'b1, 8'h99, 1'b0);
    chk("post-reset ignore flag", write_flag, 1'b0);
    chk("post-reset ocw1", ocw1, OCW1_RST);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
